// File: rtl/seg_scan_capture.sv
// Passive capture of a multiplexed 4-digit seven-segment display: qualifies each
// strobed digit, decodes it to a nibble and publishes complete 16-bit frames.
module seg_scan_capture #(
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic        ms_4_clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        clr_err,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  digit_mask,
  output logic        err_seg,
  output logic        err_an,
  output logic        stale,
  output logic [7:0]  frame_count,
  output logic [1:0]  fsm_state_o
);

  // Encoding is visible on fsm_state_o: IDLE=0, QUALIFY=1, HELD=2.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [3:0] STABLE_N     = 4'(STABLE_CYCLES);
  localparam logic [7:0] TIMEOUT_N    = 8'(TIMEOUT);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [3:0]  an_meta_q, an_sync_q;
  logic [6:0]  seg_meta_q, seg_sync_q;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] pair_q, pair_d;
  logic [10:0] pair_cur;

  logic [15:0] slots_q, slots_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic [7:0]  fcount_q, fcount_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        stale_q, stale_d;
  logic        err_seg_q, err_seg_d;
  logic        err_an_q, err_an_d;

  logic [3:0]  an_low;
  logic        an_idle, an_one, an_multi;
  logic [1:0]  digit_idx;
  logic        dec_ok;
  logic [3:0]  dec_nib;
  logic        accept, restart, new_err_an, new_err_seg;
  logic [3:0]  mask_new;

  always_ff @(posedge ms_4_clk or posedge reset) begin
    if (reset) begin
      an_meta_q  <= 4'hF;
      an_sync_q  <= 4'hF;
      seg_meta_q <= 7'h7F;
      seg_sync_q <= 7'h7F;
    end else begin
      an_meta_q  <= an;
      an_sync_q  <= an_meta_q;
      seg_meta_q <= seg;
      seg_sync_q <= seg_meta_q;
    end
  end

  assign pair_cur = {an_sync_q, seg_sync_q};
  assign an_low   = ~an_sync_q;
  assign an_idle  = (an_low == 4'd0);
  assign an_one   = !an_idle && ((an_low & (an_low - 4'd1)) == 4'd0);
  assign an_multi = !an_idle && !an_one;

  always_comb begin
    digit_idx = 2'd0;
    case (an_low)
      4'b0010: digit_idx = 2'd1;
      4'b0100: digit_idx = 2'd2;
      4'b1000: digit_idx = 2'd3;
      default: digit_idx = 2'd0;
    endcase
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (seg_sync_q)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Qualification FSM. A multi-low strobe overrides every state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pair_d     = pair_q;
    accept     = 1'b0;
    restart    = 1'b0;
    new_err_an = 1'b0;
    if (an_multi) begin
      new_err_an = 1'b1;
      state_d    = IDLE;
      cnt_d      = 4'd0;
      pair_d     = pair_cur;
    end else begin
      case (state_q)
        IDLE: begin
          if (an_one) restart = 1'b1;
        end
        QUALIFY: begin
          if (pair_cur == pair_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == STABLE_N) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else if (an_idle) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            pair_d  = pair_cur;
          end else begin
            restart = 1'b1;
          end
        end
        HELD: begin
          if (pair_cur != pair_q) begin
            if (an_idle) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              pair_d  = pair_cur;
            end else begin
              restart = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      // A new strobe pair counts as its own first stable sample.
      if (restart) begin
        pair_d = pair_cur;
        cnt_d  = 4'd1;
        if (STABLE_N == 4'd1) begin
          accept  = 1'b1;
          state_d = HELD;
        end else begin
          state_d = QUALIFY;
        end
      end
    end
  end

  // Frame assembly. An accept restarts the timeout, so completion always beats timeout.
  always_comb begin
    slots_d     = slots_q;
    mask_d      = mask_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    fcount_d    = fcount_q;
    stale_d     = stale_q;
    to_cnt_d    = to_cnt_q;
    new_err_seg = 1'b0;
    mask_new    = mask_q;
    if (accept) begin
      to_cnt_d = 8'd0;
      if (dec_ok) begin
        slots_d[{digit_idx, 2'b00} +: 4] = dec_nib;
        mask_new = mask_q | (4'b0001 << digit_idx);
        if (mask_new == 4'hF) begin
          value_d  = slots_d;
          valid_d  = 1'b1;
          mask_d   = 4'h0;
          fcount_d = fcount_q + 8'd1;
          stale_d  = 1'b0;
        end else begin
          mask_d = mask_new;
        end
      end else begin
        new_err_seg = 1'b1;
      end
    end else begin
      if (to_cnt_q != TIMEOUT_N) to_cnt_d = to_cnt_q + 8'd1;
      if (to_cnt_q == TIMEOUT_LAST && mask_q != 4'h0) begin
        mask_d  = 4'h0;
        stale_d = 1'b1;
      end
    end
    err_seg_d = (err_seg_q & ~clr_err) | new_err_seg;
    err_an_d  = (err_an_q & ~clr_err) | new_err_an;
  end

  always_ff @(posedge ms_4_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pair_q    <= {4'hF, 7'h7F};
      slots_q   <= 16'h0000;
      mask_q    <= 4'h0;
      value_q   <= 16'h0000;
      valid_q   <= 1'b0;
      fcount_q  <= 8'h00;
      to_cnt_q  <= 8'd0;
      stale_q   <= 1'b0;
      err_seg_q <= 1'b0;
      err_an_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pair_q    <= pair_d;
      slots_q   <= slots_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      fcount_q  <= fcount_d;
      to_cnt_q  <= to_cnt_d;
      stale_q   <= stale_d;
      err_seg_q <= err_seg_d;
      err_an_q  <= err_an_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign digit_mask  = mask_q;
  assign err_seg     = err_seg_q;
  assign err_an      = err_an_q;
  assign stale       = stale_q;
  assign frame_count = fcount_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus a randomized scan checked
// against a run-length reference model of the display capture.
module tb_seg_scan_capture;

  localparam int STABLE = 2;
  localparam int TMO    = 64;

  logic        ms_4_clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        clr_err;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  digit_mask;
  logic        err_seg;
  logic        err_an;
  logic        stale;
  logic [7:0]  frame_count;
  logic [1:0]  fsm_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
    .ms_4_clk    (ms_4_clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .clr_err     (clr_err),
    .value       (value),
    .value_valid (value_valid),
    .digit_mask  (digit_mask),
    .err_seg     (err_seg),
    .err_an      (err_an),
    .stale       (stale),
    .frame_count (frame_count),
    .fsm_state_o (fsm_state_o)
  );

  // clock / reset
  always #5 ms_4_clk = ~ms_4_clk;

  // reference model: a digit is accepted when its strobe has been seen for
  // exactly STABLE consecutive synchronized samples
  logic [10:0] m_hist[$];
  logic [10:0] m_prev, m_eff;
  int          m_run, m_since, m_lows, m_dec, m_idx;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_mask;
  logic [15:0] m_value;
  logic        m_vv, m_stale, m_err_seg, m_err_an, m_new_seg, m_new_an;
  logic [7:0]  m_fc;
  int          m_pulses = 0;
  int          dut_pulses = 0;

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  always @(posedge ms_4_clk or posedge reset) begin
    if (reset) begin
      m_hist = {};
      m_hist.push_back({4'hF, 7'h7F});
      m_hist.push_back({4'hF, 7'h7F});
      m_prev = {4'hF, 7'h7F};
      m_run = 1000; m_since = 0;
      for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
      m_mask = 4'h0; m_value = 16'h0; m_vv = 1'b0; m_fc = 8'h0;
      m_stale = 1'b0; m_err_seg = 1'b0; m_err_an = 1'b0;
    end else begin
      m_eff = m_hist.pop_front();
      m_hist.push_back({an, seg});
      if (m_eff == m_prev) m_run++;
      else m_run = 1;
      m_prev = m_eff;
      m_lows = $countones(~m_eff[10:7]);
      m_new_an = (m_lows >= 2);
      m_new_seg = 1'b0;
      m_vv = 1'b0;
      if (m_lows == 1 && m_run == STABLE) begin
        m_since = 0;
        m_dec = decode(m_eff[6:0]);
        if (m_dec < 0) m_new_seg = 1'b1;
        else begin
          m_idx = 0;
          for (int i = 0; i < 4; i++) if (m_eff[7+i] == 1'b0) m_idx = i;
          m_slot[m_idx] = 4'(m_dec);
          m_mask[m_idx] = 1'b1;
          if (m_mask == 4'hF) begin
            m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_vv = 1'b1;
            m_pulses++;
            m_mask = 4'h0;
            m_fc = m_fc + 8'd1;
            m_stale = 1'b0;
          end
        end
      end else begin
        m_since++;
        if (m_since == TMO && m_mask != 4'h0) begin
          m_mask = 4'h0;
          m_stale = 1'b1;
        end
      end
      m_err_seg = (m_err_seg && !clr_err) || m_new_seg;
      m_err_an  = (m_err_an && !clr_err) || m_new_an;
    end
  end

  always @(negedge ms_4_clk) if (value_valid === 1'b1) dut_pulses++;

  // driver tasks
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int cycles);
    an = a;
    seg = s;
    repeat (cycles) @(negedge ms_4_clk);
  endtask

  task automatic scan_frame(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3, input int hold);
    drive(4'b1110, seg_tab[d0], hold);
    drive(4'b1101, seg_tab[d1], hold);
    drive(4'b1011, seg_tab[d2], hold);
    drive(4'b0111, seg_tab[d3], hold);
  endtask

  task automatic test_reset();
    reset = 1'b1; clr_err = 1'b0; an = 4'hF; seg = 7'h7F;
    repeat (3) @(negedge ms_4_clk);
    n_checks++; if (value !== 16'h0) begin n_fail++; $display("FAIL reset_value: got %h want 0000", value); end
    n_checks++; if (value_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", value_valid); end
    n_checks++; if (digit_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %b want 0000", digit_mask); end
    n_checks++; if (err_seg !== 1'b0 || err_an !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b want 00", err_seg, err_an); end
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL reset_stale: got %b want 0", stale); end
    n_checks++; if (frame_count !== 8'h0) begin n_fail++; $display("FAIL reset_fcount: got %h want 00", frame_count); end
    n_checks++; if (fsm_state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0 (IDLE)", fsm_state_o); end
    reset = 1'b0;
    @(negedge ms_4_clk);
  endtask

  task automatic test_basic_scan();
    int p0;
    p0 = dut_pulses;
    drive(4'b1110, 7'b0000000, 4);
    drive(4'b1101, 7'b1001100, 4);
    drive(4'b1011, 7'b0010010, 4);
    drive(4'b0111, 7'b1001111, 4);
    drive(4'b1111, 7'h7F, 4);
    n_checks++; if (value !== 16'h1248) begin n_fail++; $display("FAIL basic_value: got %h want 1248", value); end
    n_checks++; if (dut_pulses - p0 !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", dut_pulses - p0); end
    n_checks++; if (frame_count !== 8'h01) begin n_fail++; $display("FAIL basic_fcount: got %h want 01", frame_count); end
    n_checks++; if (digit_mask !== 4'h0) begin n_fail++; $display("FAIL basic_mask: got %b want 0000", digit_mask); end
  endtask

  task automatic test_short_hold();
    drive(4'b1101, seg_tab[5], 1);
    drive(4'b1111, 7'h7F, 4);
    n_checks++; if (digit_mask !== 4'h0) begin n_fail++; $display("FAIL short_hold_mask: got %b want 0000", digit_mask); end
    n_checks++; if (digit_mask !== m_mask) begin n_fail++; $display("FAIL short_hold_model: got %b want %b", digit_mask, m_mask); end
  endtask

  task automatic test_bad_seg();
    drive(4'b1110, 7'b1111110, 4);
    drive(4'b1111, 7'h7F, 3);
    n_checks++; if (err_seg !== 1'b1) begin n_fail++; $display("FAIL bad_seg_flag: got %b want 1", err_seg); end
    n_checks++; if (digit_mask[0] !== 1'b0) begin n_fail++; $display("FAIL bad_seg_mask0: got %b want 0", digit_mask[0]); end
    clr_err = 1'b1;
    @(negedge ms_4_clk);
    clr_err = 1'b0;
    @(negedge ms_4_clk);
    n_checks++; if (err_seg !== 1'b0) begin n_fail++; $display("FAIL bad_seg_clear: got %b want 0", err_seg); end
  endtask

  task automatic test_err_an();
    drive(4'b1100, seg_tab[2], 4);
    n_checks++; if (err_an !== 1'b1) begin n_fail++; $display("FAIL err_an_flag: got %b want 1", err_an); end
    n_checks++; if (fsm_state_o !== 2'd0) begin n_fail++; $display("FAIL err_an_state: got %0d want 0 (IDLE)", fsm_state_o); end
    clr_err = 1'b1;
    repeat (2) @(negedge ms_4_clk);
    clr_err = 1'b0;
    n_checks++; if (err_an !== 1'b1) begin n_fail++; $display("FAIL err_an_clr_collide: got %b want 1", err_an); end
    drive(4'b1111, 7'h7F, 3);
    clr_err = 1'b1;
    @(negedge ms_4_clk);
    clr_err = 1'b0;
    @(negedge ms_4_clk);
    n_checks++; if (err_an !== 1'b0) begin n_fail++; $display("FAIL err_an_clear: got %b want 0", err_an); end
  endtask

  task automatic test_timeout();
    logic [3:0] d [4];
    logic [15:0] exp_v;
    drive(4'b1110, seg_tab[3], 4);
    drive(4'b1101, seg_tab[5], 4);
    n_checks++; if (digit_mask !== 4'b0011) begin n_fail++; $display("FAIL timeout_partial: got %b want 0011", digit_mask); end
    drive(4'b1111, 7'h7F, 70);
    n_checks++; if (digit_mask !== 4'h0) begin n_fail++; $display("FAIL timeout_mask: got %b want 0000", digit_mask); end
    n_checks++; if (stale !== 1'b1) begin n_fail++; $display("FAIL timeout_stale: got %b want 1", stale); end
    for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 15));
    exp_v = {d[3], d[2], d[1], d[0]};
    scan_frame(d[0], d[1], d[2], d[3], 3);
    drive(4'b1111, 7'h7F, 4);
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL timeout_restale: got %b want 0", stale); end
    n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL timeout_value: got %h want %h", value, exp_v); end
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [7:0] fc0;
    logic [15:0] exp_v;
    logic [3:0] d [4];
    p0 = dut_pulses;
    fc0 = frame_count;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 15));
      exp_v = {d[3], d[2], d[1], d[0]};
      scan_frame(d[0], d[1], d[2], d[3], 3);
    end
    drive(4'b1111, 7'h7F, 4);
    n_checks++; if (dut_pulses - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", dut_pulses - p0); end
    n_checks++; if (frame_count !== fc0 + 8'd2) begin n_fail++; $display("FAIL b2b_fcount: got %h want %h", frame_count, fc0 + 8'd2); end
    n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL b2b_value: got %h want %h", value, exp_v); end
  endtask

  task automatic test_reset_mid();
    int p0;
    drive(4'b1110, seg_tab[1], 4);
    drive(4'b1101, seg_tab[2], 4);
    drive(4'b1011, seg_tab[3], 4);
    reset = 1'b1;
    repeat (2) @(negedge ms_4_clk);
    n_checks++; if (value !== 16'h0 || frame_count !== 8'h0) begin n_fail++; $display("FAIL midreset_value: got %h/%h want 0000/00", value, frame_count); end
    n_checks++; if (digit_mask !== 4'h0 || value_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_mask: got %b/%b want 0000/0", digit_mask, value_valid); end
    n_checks++; if (stale !== 1'b0 || err_seg !== 1'b0 || err_an !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got %b%b%b want 000", stale, err_seg, err_an); end
    reset = 1'b0;
    p0 = dut_pulses;
    drive(4'b0111, seg_tab[9], 4);
    drive(4'b1111, 7'h7F, 4);
    n_checks++; if (dut_pulses - p0 !== 0) begin n_fail++; $display("FAIL midreset_pulse: got %0d want 0", dut_pulses - p0); end
    n_checks++; if (digit_mask !== 4'b1000) begin n_fail++; $display("FAIL midreset_digit3: got %b want 1000", digit_mask); end
  endtask

  task automatic test_random();
    int r, i, j, hold;
    logic [3:0] a;
    logic [6:0] s;
    for (int step = 0; step < 400; step++) begin
      r = $urandom_range(0, 39);
      i = $urandom_range(0, 3);
      if (r == 0) begin
        j = (i + 1 + $urandom_range(0, 2)) % 4;
        a = 4'hF & ~(4'b0001 << i) & ~(4'b0001 << j);
      end else if (r < 8) a = 4'hF;
      else a = ~(4'b0001 << i);
      s = ($urandom_range(0, 9) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 15)];
      hold = (r == 1) ? 70 : $urandom_range(1, 5);
      clr_err = ($urandom_range(0, 15) == 0);
      an = a;
      seg = s;
      for (int c = 0; c < hold; c++) begin
        @(negedge ms_4_clk);
        clr_err = 1'b0;
        n_checks++; if (value !== m_value) begin n_fail++; $display("FAIL rnd_value: got %h want %h", value, m_value); end
        n_checks++; if (value_valid !== m_vv) begin n_fail++; $display("FAIL rnd_valid: got %b want %b", value_valid, m_vv); end
        n_checks++; if (digit_mask !== m_mask) begin n_fail++; $display("FAIL rnd_mask: got %b want %b", digit_mask, m_mask); end
        n_checks++; if (frame_count !== m_fc) begin n_fail++; $display("FAIL rnd_fcount: got %h want %h", frame_count, m_fc); end
        n_checks++; if (stale !== m_stale) begin n_fail++; $display("FAIL rnd_stale: got %b want %b", stale, m_stale); end
        n_checks++; if (err_seg !== m_err_seg) begin n_fail++; $display("FAIL rnd_err_seg: got %b want %b", err_seg, m_err_seg); end
        n_checks++; if (err_an !== m_err_an) begin n_fail++; $display("FAIL rnd_err_an: got %b want %b", err_an, m_err_an); end
      end
    end
    n_checks++; if (dut_pulses !== m_pulses) begin n_fail++; $display("FAIL rnd_pulse_total: got %0d want %0d", dut_pulses, m_pulses); end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_short_hold();
    test_bad_seg();
    test_err_an();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 2: consecutive identical synchronized samples needed to accept a digit; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 64: cycles without an accepted digit before a partial frame is discarded; legal range 8..255.
REQ-003 Clocking and reset SHALL be exactly: reset reset, asynchronous, active-high; clock ms_4_clk.
REQ-004 ms_4_clk  input  1  scan-rate clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 an  input  4  monitored anode strobes, active-low; an[i]=0 selects digit i.
REQ-007 seg  input  7  monitored segments, active-low, order {a,b,c,d,e,f,g} = seg[6:0].
REQ-008 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-009 value  output  16  last complete frame; digit i is value[4i+3:4i].
REQ-010 value_valid  output  1  one-cycle pulse when value is updated.
REQ-011 digit_mask  output  4  digits captured in the current partial frame.
REQ-012 err_seg  output  1  sticky flag: undecodable segment pattern was accepted.
REQ-013 err_an  output  1  sticky flag: an had two or more bits low.
REQ-014 stale  output  1  high after a timeout; cleared by the next frame completion.
REQ-015 frame_count  output  8  count of completed frames, wraps 255 to 0.

Function
REQ-016 an and seg SHALL each pass through a 2-flop synchronizer; all logic SHALL use the synchronized copies, giving 2 cycles of input latency.
REQ-017 Decode table (seg to nibble), hex 0..F SHALL be: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000; any other pattern is undecodable.
REQ-018 The FSM SHALL have states IDLE, QUALIFY and HELD.
REQ-019 IDLE: when an=1111, stay in IDLE; when an has exactly one bit low, go to QUALIFY and load the stability counter with 1.
REQ-020 QUALIFY: if {an,seg} is unchanged, increment the counter; when the counter reaches STABLE_CYCLES, accept the digit and go to HELD; if {an,seg} changes, restart QUALIFY with the new pair, or go to IDLE if an=1111.
REQ-021 HELD: accept no further digits until {an,seg} changes; then branch as from IDLE.
REQ-022 When STABLE_CYCLES=1, a digit SHALL be accepted on its first synchronized sample.
REQ-023 Accept of a decodable pattern: write the nibble into frame slot i and set digit_mask[i]; re-accepting an already set slot overwrites that slot (latest wins).
REQ-024 Accept of an undecodable pattern: set err_seg; leave slot i and digit_mask unchanged.
REQ-025 An an value with two or more bits low SHALL set err_an and force IDLE; no digit is accepted.
REQ-026 When digit_mask would become 1111: on the next edge, value takes the 4 slots, value_valid=1 for one cycle, digit_mask=0000, frame_count increments, and stale=0.
REQ-027 Timeout counter: reset on every accept; on reaching TIMEOUT with digit_mask not 0000, clear digit_mask and set stale.
REQ-028 If frame completion and timeout occur in the same cycle, completion SHALL win.
REQ-029 If clr_err and a new error occur in the same cycle, the error flag SHALL remain set.

Reset
REQ-030 On reset, every output SHALL go to zero: value=0000h, value_valid=0, digit_mask=0000, err_seg=0, err_an=0, stale=0, frame_count=00h.
REQ-031 On reset, the FSM SHALL go to IDLE, all counters and slots to 0, and synchronizers to an=1111, seg=1111111.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame, with no value_valid pulse.

Verification
REQ-033 Scan 1110/0000000 (8), 1101/1001100 (4), 1011/0010010 (2), 0111/1001111 (1), 4 cycles each -> value=1248h, one value_valid pulse, frame_count=01h.
REQ-034 Hold one digit for 1 cycle with STABLE_CYCLES=2 -> no accept; digit_mask unchanged.
REQ-035 seg=1111110 on digit 0 for 4 cycles -> err_seg=1, digit_mask[0]=0; clr_err -> err_seg=0.
REQ-036 an=1100 -> err_an=1, FSM in IDLE.
REQ-037 Capture 2 digits, then an=1111 for 70 cycles -> digit_mask=0000, stale=1; next full scan -> stale=0.
REQ-038 Assert reset after 3 digits -> all outputs 0; 4th digit alone -> no value_valid.
